clk_div_monitor: RTL and testbench

Receive-side checker for divided clocks produced by the odd/even frequency dividers.
- Samples a divided clock (div_clk_in) in the fast clk domain and measures its high time, low time and period in clk cycles.
- Declares lock once the measured ratio matches the expected divide factor for several consecutive periods.
- Sits beside each divider instance as a built-in self-check; outputs feed status registers.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_monitor_if.sv | 23 ++
 rtl/clk_div_sync_edge.sv | 30 +++
 rtl/clk_div_monitor.sv | 162 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } mon_state_t;

    localparam int DEF_CNT_W = 8;
    localparam logic [31:0] DUTY_TOL = 32'd1;

    // True when the high and low phases differ by more than the tolerance.
    function automatic logic duty_imbalanced(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return (diff > DUTY_TOL);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control and status bundle between a divider self-check monitor and its status block.
interface clk_div_monitor_if #(parameter int CNT_W = clk_div_pkg::DEF_CNT_W);
    logic             enable;
    logic             div_clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             meas_valid;
    logic             locked;
    logic             ratio_err;
    logic             duty_err;
    logic             timeout;

    modport master (
        output enable, div_clk_in,
        input  period, high_time, low_time, meas_valid, locked, ratio_err, duty_err, timeout
    );

    modport slave (
        input  enable, div_clk_in,
        output period, high_time, low_time, meas_valid, locked, ratio_err, duty_err, timeout
    );
endinterface

// File: rtl/clk_div_sync_edge.sv
// Two-flop synchronizer for the divided clock plus registered rise/fall pulse generator.
module clk_div_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic sync1_r, sync2_r, prev_r, rise_r, fall_r;

    // Synchronize the asynchronous input and flag each transition for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a divided clock and declares lock at EXP_DIV.
// Optional duty-cycle check enabled by defining CLK_DIV_MON_DUTY_CHECK_EN.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_DIV  = 5,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    clk_div_monitor_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   SUM_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   EXP_P    = (CNT_W+1)'(EXP_DIV);
    localparam logic [MW-1:0]    LOCK_M   = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             rise_s, fall_s;
    mon_state_t       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, high_r, high_s;
    logic [CNT_W-1:0] period_r, period_s, high_time_r, high_time_s, low_time_r, low_time_s;
    logic [MW-1:0]    match_r, match_s;
    logic             meas_valid_r, meas_valid_s, ratio_err_r, ratio_err_s;
    logic             duty_err_r, duty_err_s, timeout_r, timeout_s, locked_r, locked_s;
    logic [CNT_W:0]   sum_s;
    logic             duty_bad_s, clear_s;

    clk_div_sync_edge u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.div_clk_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, counter, measurement and lock logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        high_s       = high_r;
        period_s     = period_r;
        high_time_s  = high_time_r;
        low_time_s   = low_time_r;
        match_s      = match_r;
        meas_valid_s = 1'b0;
        ratio_err_s  = 1'b0;
        duty_err_s   = 1'b0;
        timeout_s    = 1'b0;
        clear_s      = 1'b0;
        sum_s        = {1'b0, high_r} + {1'b0, cnt_r};
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
        duty_bad_s   = duty_imbalanced(32'(high_r), 32'(cnt_r));
`else
        duty_bad_s   = 1'b0;
`endif
        if (!bus.enable) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            match_s = {MW{1'b0}};
            clear_s = 1'b1;
        end else if ((state_r != IDLE) && (cnt_r == CNT_MAX)) begin
            // Stuck divided clock: abandon the measurement and resynchronize.
            state_s   = WAIT_RISE;
            cnt_s     = CNT_ZERO;
            match_s   = {MW{1'b0}};
            timeout_s = 1'b1;
            clear_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = WAIT_RISE;
                    cnt_s   = CNT_ZERO;
                end
                WAIT_RISE: begin
                    if (rise_s) begin
                        cnt_s   = CNT_ONE;
                        state_s = MEAS_HIGH;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    if (fall_s) begin
                        high_s  = cnt_r;
                        cnt_s   = CNT_ONE;
                        state_s = MEAS_LOW;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        high_time_s  = high_r;
                        low_time_s   = cnt_r;
                        period_s     = (sum_s > SUM_MAX) ? CNT_MAX : sum_s[CNT_W-1:0];
                        meas_valid_s = 1'b1;
                        ratio_err_s  = (sum_s != EXP_P);
                        duty_err_s   = duty_bad_s;
                        if (!ratio_err_s && !duty_bad_s) begin
                            match_s = (match_r == LOCK_M) ? match_r : (match_r + MW'(1'b1));
                        end else begin
                            match_s = {MW{1'b0}};
                        end
                        cnt_s   = CNT_ONE;
                        state_s = MEAS_HIGH;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
        locked_s = (match_r == LOCK_M) && !clear_s;
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            high_r       <= CNT_ZERO;
            period_r     <= CNT_ZERO;
            high_time_r  <= CNT_ZERO;
            low_time_r   <= CNT_ZERO;
            match_r      <= {MW{1'b0}};
            meas_valid_r <= 1'b0;
            ratio_err_r  <= 1'b0;
            duty_err_r   <= 1'b0;
            timeout_r    <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            high_r       <= high_s;
            period_r     <= period_s;
            high_time_r  <= high_time_s;
            low_time_r   <= low_time_s;
            match_r      <= match_s;
            meas_valid_r <= meas_valid_s;
            ratio_err_r  <= ratio_err_s;
            duty_err_r   <= duty_err_s;
            timeout_r    <= timeout_s;
            locked_r     <= locked_s;
        end
    end

    assign bus.period     = period_r;
    assign bus.high_time  = high_time_r;
    assign bus.low_time   = low_time_r;
    assign bus.meas_valid = meas_valid_r;
    assign bus.ratio_err  = ratio_err_r;
    assign bus.duty_err   = duty_err_r;
    assign bus.timeout    = timeout_r;
    assign bus.locked     = locked_r;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed-vector bench for clk_div_monitor (CNT_W=8, EXP_DIV=5, LOCK_CNT=4).
module tb_clk_div_monitor;
    import clk_div_pkg::*;

`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    localparam int DUTY_ON = 1;
`else
    localparam int DUTY_ON = 0;
`endif

    typedef struct {
        int en; int hi; int lo; int n;
        int mv; int per; int h; int l; int rerr; int derr; int lk;
    } row_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int cyc = 0, mv_cnt = 0, mv_cyc = 0, to_cnt = 0, to_cyc = 0, stray = 0;
    int last_rerr = 0, last_derr = 0, lk_rise_mv = 0, lk_rise_gap = 0, lk_fall_gap = 0;
    logic lk_prev = 1'b0;

    clk_div_monitor_if #(.CNT_W(8)) bus ();

    clk_div_monitor #(.CNT_W(8), .EXP_DIV(5), .LOCK_CNT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record pulse events on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.meas_valid) begin
            mv_cnt    <= mv_cnt + 1;
            mv_cyc    <= cyc;
            last_rerr <= int'(bus.ratio_err);
            last_derr <= int'(bus.duty_err);
        end else if (bus.ratio_err || bus.duty_err) begin
            stray <= stray + 1;
        end
        if (bus.timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
        if (bus.locked && !lk_prev) begin
            lk_rise_mv  <= mv_cnt;
            lk_rise_gap <= cyc - mv_cyc;
        end
        if (!bus.locked && lk_prev) lk_fall_gap <= cyc - mv_cyc;
        lk_prev <= bus.locked;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".period"},     int'(bus.period), 0);
        check({tag, ".high_time"},  int'(bus.high_time), 0);
        check({tag, ".low_time"},   int'(bus.low_time), 0);
        check({tag, ".meas_valid"}, int'(bus.meas_valid), 0);
        check({tag, ".locked"},     int'(bus.locked), 0);
        check({tag, ".ratio_err"},  int'(bus.ratio_err), 0);
        check({tag, ".duty_err"},   int'(bus.duty_err), 0);
        check({tag, ".timeout"},    int'(bus.timeout), 0);
    endtask

    task automatic apply_row(input row_t r, input string tag);
        int mv0;
        mv0 = mv_cnt;
        bus.enable = (r.en != 0);
        for (int i = 0; i < r.n; i++) begin
            bus.div_clk_in = 1'b1;
            repeat (r.hi) @(posedge clk);
            #1;
            bus.div_clk_in = 1'b0;
            repeat (r.lo) @(posedge clk);
            #1;
        end
        check({tag, ".mv_count"},  mv_cnt - mv0, r.mv);
        check({tag, ".period"},    int'(bus.period), r.per);
        check({tag, ".high_time"}, int'(bus.high_time), r.h);
        check({tag, ".low_time"},  int'(bus.low_time), r.l);
        check({tag, ".ratio_err"}, last_rerr, r.rerr);
        check({tag, ".duty_err"},  last_derr, r.derr);
        check({tag, ".locked"},    int'(bus.locked), r.lk);
    endtask

    row_t rows[8];
    row_t relock;

    initial begin
        //          en hi lo  n  mv per h  l  rerr derr       lk
        rows[0] = '{1, 3, 2, 6, 5, 5, 3, 2, 0, 0,          1};
        rows[1] = '{1, 3, 3, 2, 2, 6, 3, 3, 1, 0,          0};
        rows[2] = '{1, 3, 2, 6, 6, 5, 3, 2, 0, 0,          1};
        rows[3] = '{1, 2, 3, 6, 6, 5, 2, 3, 0, 0,          1};
        rows[4] = '{1, 4, 1, 6, 6, 5, 4, 1, 0, DUTY_ON,    1 - DUTY_ON};
        rows[5] = '{1, 4, 4, 3, 3, 8, 4, 4, 1, 0,          0};
        rows[6] = '{0, 3, 2, 2, 0, 8, 4, 4, 1, 0,          0};
        rows[7] = '{1, 3, 2, 6, 5, 5, 3, 2, 0, 0,          1};
        relock  = '{1, 3, 2, 6, 5, 5, 3, 2, 0, 0,          1};

        bus.enable     = 1'b0;
        bus.div_clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            apply_row(rows[i], $sformatf("row%0d", i));
            if (i == 0) begin
                check("lock.after_mv", lk_rise_mv, 4);
                check("lock.rise_gap", lk_rise_gap, 1);
            end
            if (i == 1) check("lock.fall_gap", lk_fall_gap, 1);
        end

        // Divided clock stuck high long enough to saturate the phase counter.
        begin
            int mv0, to0;
            mv0 = mv_cnt;
            to0 = to_cnt;
            bus.div_clk_in = 1'b1;
            repeat (300) @(posedge clk);
            #1;
            check("tmo.count",  to_cnt - to0, 1);
            check("tmo.gap",    to_cyc - mv_cyc, 255);
            check("tmo.mv",     mv_cnt - mv0, 1);
            check("tmo.locked", int'(bus.locked), 0);
            check("tmo.period", int'(bus.period), 5);
            bus.div_clk_in = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        apply_row(relock, "tmo_relock");

        // Reset pulse while locked and measuring the low phase.
        bus.div_clk_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.div_clk_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst.pre_locked", int'(bus.locked), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        apply_row(relock, "rst_relock");

        check("stray_err_pulses", stray, 0);
        check("total_timeouts", to_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
